dehaze_frame_seq: RTL
=====================

DEHAZE_FRAME_SEQ -- requirements
Module: dehaze_frame_seq

Interface
REQ-001 SHALL have parameter IMG_W, default 128, pixels per image row (>=3).
REQ-002 SHALL have parameter IMG_H, default 128, rows per image (>=3); IMG_W*IMG_H SHALL be <= 2^ADDR_W.
REQ-003 SHALL have parameter ADDR_W, default 14, image-BRAM address width.
REQ-004 SHALL have parameter RD_LAT, default 2, gen_clk cycles from mem_rd to pixel data at window-buffer input.
REQ-005 gen_clk  input  1  pixel-domain clock; all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 start  input  1  request one frame; sampled only in IDLE.
REQ-008 stall  input  1  downstream backpressure; freezes read sequencing.
REQ-009 galc_done  input  1  atmospheric-light result valid, from GALC.
REQ-010 addr  output  ADDR_W  image-BRAM read address.
REQ-011 mem_rd  output  1  addr valid this cycle; shifts window buffer.
REQ-012 win_valid  output  1  3x3 window at buffer output is complete and in-image.
REQ-013 galc_rd  output  1  GALC accumulate/read enable.
REQ-014 pass  output  1  0 = atmospheric-light pass, 1 = recovery pass.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 frame_done  output  1  one-cycle pulse at end of frame.

Function
REQ-017 States: IDLE, STREAM, DRAIN, WAIT_ATM, DONE; binary encoding, illegal codes go to IDLE.
REQ-018 IDLE: start=1 -> STREAM, addr=0, pass=0; start ignored in any other state.
REQ-019 STREAM, stall=0: mem_rd=1, addr increments by 1 per cycle from 0 to IMG_W*IMG_H-1; row/col counters track addr, col wraps IMG_W-1 -> 0 with row+1.
REQ-020 STREAM, stall=1: mem_rd=0, addr/row/col hold; no pixel lost or repeated.
REQ-021 Cycle after last address issued (mem_rd with addr=IMG_W*IMG_H-1) -> DRAIN, mem_rd=0.
REQ-022 Valid pipeline: mem_rd, row, col delayed RD_LAT cycles; win_valid=1 iff delayed mem_rd=1 and delayed row>=2 and delayed col>=2.
REQ-023 Windows per pass SHALL equal (IMG_W-2)*(IMG_H-2); edge windows never flagged.
REQ-024 DRAIN lasts exactly RD_LAT cycles, then -> WAIT_ATM if pass=0, else -> DONE.
REQ-025 galc_rd = win_valid while pass=0; galc_rd=1 continuously in WAIT_ATM; galc_rd=0 when pass=1.
REQ-026 WAIT_ATM: hold until galc_done=1; galc_done outside WAIT_ATM ignored.
REQ-027 galc_done and stall simultaneous: galc_done wins; stall affects STREAM only.
REQ-028 DONE: frame_done=1 for one cycle, -> IDLE; pass cleared to 0 on IDLE entry.

Reset
REQ-029 rst=1 at a gen_clk edge SHALL force IDLE from any state, including mid-STREAM/DRAIN.
REQ-030 Reset values: addr=0, mem_rd=0, win_valid=0, galc_rd=0, pass=0, busy=0, frame_done=0; row/col counters and whole valid pipeline cleared, in-flight pixels discarded.

Configuration
REQ-031 Macro DEHAZE_SEQ_PASS2_EN defined: galc_done in WAIT_ATM -> STREAM with pass=1, addr=0, second full raster pass, then DRAIN -> DONE.
REQ-032 Macro undefined: galc_done in WAIT_ATM -> DONE; pass stays 0; single pass per frame.

Verification
REQ-033 IMG_W=4, IMG_H=4, RD_LAT=2, start pulse, no stall -> addr 0..15 on 16 consecutive cycles, exactly 4 win_valid pulses, first 12 cycles after addr=0.
REQ-034 Same, stall high 3 cycles while addr=5 -> addr holds 5, mem_rd=0 for 3 cycles, total reads still 16, win_valid count 4.
REQ-035 galc_done held low 50 cycles after DRAIN -> stays WAIT_ATM, galc_rd=1, busy=1; galc_done=1 -> frame_done pulse (macro off) or pass=1 rescan of 16 addresses (macro on).
REQ-036 rst asserted when addr=9 -> next cycle all outputs at REQ-030 values, no win_valid from in-flight reads; new start restarts at addr=0.
REQ-037 start asserted during STREAM and galc_done during STREAM -> both ignored, sequence identical to REQ-033.

Source files
------------

// File: rtl/dehaze_frame_seq.sv
// Dehaze frame sequencer: rasters the image BRAM once per pass, flags complete
// in-image 3x3 windows after the read latency, and handshakes with GALC between passes.
// Optional macro DEHAZE_SEQ_PASS2_EN adds a second (recovery) raster pass after GALC completes.
module dehaze_frame_seq #(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int ADDR_W = 14,
  parameter int RD_LAT = 2
) (
  input  logic              gen_clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  input  logic              galc_done,
  output logic [ADDR_W-1:0] addr,
  output logic              mem_rd,
  output logic              win_valid,
  output logic              galc_rd,
  output logic              pass,
  output logic              busy,
  output logic              frame_done
);

  localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 2;
  localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 2;
  localparam int DW = (RD_LAT > 1) ? $clog2(RD_LAT + 1) : 1;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [CW-1:0]     LAST_COL  = CW'(IMG_W - 1);
  localparam logic [DW-1:0]     LAST_DRN  = DW'(RD_LAT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_STREAM = 3'd1;
  localparam logic [2:0] S_DRAIN  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]    state;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [DW-1:0] drain_cnt;

  // Read-side pipeline: mirrors the BRAM latency so row/col line up with the data.
  logic [RD_LAT-1:0] vld_pipe;
  logic [RW-1:0]     row_pipe [RD_LAT];
  logic [CW-1:0]     col_pipe [RD_LAT];

  // Sequencer: state, raster position and pass flag.
  always_ff @(posedge gen_clk) begin
    if (rst) begin
      state     <= S_IDLE;
      addr      <= '0;
      row       <= '0;
      col       <= '0;
      pass      <= 1'b0;
      drain_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_STREAM;
            addr  <= '0;
            row   <= '0;
            col   <= '0;
            pass  <= 1'b0;
          end
        end
        S_STREAM: begin
          // A stalled cycle issues no read, so holding position loses nothing.
          if (!stall) begin
            if (addr == LAST_ADDR) begin
              state     <= S_DRAIN;
              drain_cnt <= '0;
            end else begin
              addr <= addr + ADDR_W'(1);
              if (col == LAST_COL) begin
                col <= '0;
                row <= row + RW'(1);
              end else begin
                col <= col + CW'(1);
              end
            end
          end
        end
        S_DRAIN: begin
          // Let the last RD_LAT reads emerge from the BRAM before moving on.
          if (drain_cnt == LAST_DRN) begin
            state <= pass ? S_DONE : S_WAIT;
          end else begin
            drain_cnt <= drain_cnt + DW'(1);
          end
        end
        S_WAIT: begin
          if (galc_done) begin
`ifdef DEHAZE_SEQ_PASS2_EN
            state <= S_STREAM;
            pass  <= 1'b1;
            addr  <= '0;
            row   <= '0;
            col   <= '0;
`else
            state <= S_DONE;
`endif
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          pass  <= 1'b0;
          addr  <= '0;
        end
        default: begin
          state <= S_IDLE;
          pass  <= 1'b0;
        end
      endcase
    end
  end

  // Delay line for read-valid and raster position; reset drops in-flight pixels.
  always_ff @(posedge gen_clk) begin
    if (rst) begin
      vld_pipe <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        row_pipe[i] <= '0;
        col_pipe[i] <= '0;
      end
    end else begin
      vld_pipe[0] <= mem_rd;
      row_pipe[0] <= row;
      col_pipe[0] <= col;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        row_pipe[i] <= row_pipe[i-1];
        col_pipe[i] <= col_pipe[i-1];
      end
    end
  end

  // A window is whole once its bottom-right pixel (row>=2, col>=2) arrives.
  assign win_valid  = vld_pipe[RD_LAT-1] &&
                      (row_pipe[RD_LAT-1] >= RW'(2)) &&
                      (col_pipe[RD_LAT-1] >= CW'(2));
  assign mem_rd     = (state == S_STREAM) && !stall;
  assign galc_rd    = !pass && (win_valid || (state == S_WAIT));
  assign busy       = (state != S_IDLE);
  assign frame_done = (state == S_DONE);

endmodule
